// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and a word-wide data memory.
// One request at a time; sub-word stores are done as read-modify-write.
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic misaligned, illegal, out_of_range, fault;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] funct3,
                                              input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'd0:    res = {{24{b[7]}}, b};
      3'd1:    res = {{16{h[15]}}, h};
      3'd2:    res = word;
      3'd4:    res = {24'b0, b};
      3'd5:    res = {16'b0, h};
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [15:0] wdata,
                                              input logic [2:0] funct3, input logic [1:0] lane);
    logic [31:0] res;
    res = old;
    if (funct3 == 3'd0) begin
      res[{lane, 3'b000} +: 8] = wdata[7:0];
    end else if (lane[1]) begin
      res[31:16] = wdata;
    end else begin
      res[15:0] = wdata;
    end
    return res;
  endfunction

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3)
      3'd1, 3'd5: misaligned = req_addr[0];
      3'd2:       misaligned = |req_addr[1:0];
      default:    misaligned = 1'b0;
    endcase
    illegal      = req_we ? (req_funct3 > 3'd2) : (req_funct3 == 3'd3 || req_funct3 > 3'd5);
    out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS;
    fault        = misaligned | illegal | out_of_range;
  end

  // Combinational on state and rst so ready appears the moment reset releases.
  assign req_ready = (state_q == StIdle) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      lane_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      mem_WE     <= 1'b0;
      mem_A      <= '0;
      mem_WD     <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            if (fault) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_A <= {2'b00, req_addr[31:2]};
              if (req_we && req_funct3 == 3'd2) begin
                state_q <= StWrite;
                mem_WE  <= 1'b1;
                mem_WD  <= req_wdata;
              end else begin
                state_q <= StRead;
              end
            end
          end
        end
        StRead: begin
          if (we_q) begin
            // Old word is merged straight from the read port into the write register.
            state_q <= StWrite;
            mem_WE  <= 1'b1;
            mem_WD  <= store_merge(mem_RD, wdata_q, funct3_q, lane_q);
          end else begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= load_extend(mem_RD, funct3_q, lane_q);
            mem_A      <= '0;
          end
        end
        StWrite: begin
          state_q    <= StResp;
          mem_WE     <= 1'b0;
          mem_WD     <= '0;
          mem_A      <= '0;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= '0;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed and random requests against an arithmetic reference model.
module tb_lsu_mem_master;
  localparam int unsigned MemWords = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_WE;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_WORDS(MemWords)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_WE    (mem_WE),
    .mem_A     (mem_A),
    .mem_WD    (mem_WD),
    .mem_RD    (mem_RD)
  );

  // Memory attached to the DUT, plus a bench-side preload port.
  logic [31:0] mem     [MemWords];
  logic [31:0] ref_mem [MemWords];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  int          we_edges = 0;

  always @(posedge clk) begin
    if (mem_WE) begin
      if (mem_A < MemWords) mem[mem_A[9:0]] <= mem_WD;
      we_edges <= we_edges + 1;
    end else if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end
  end
  assign mem_RD = (mem_A < MemWords) ? mem[mem_A[9:0]] : 32'h0;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, legality and results from plain arithmetic.
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic bit ref_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if ((a / 4) >= MemWords) return 1'b1;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [31:0] a);
    int          sz;
    int          sh;
    logic [63:0] mask;
    logic [63:0] v;
    sz   = acc_size(f3);
    sh   = 8 * int'(a % 4);
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v    = ({32'b0, word} >> sh) & mask;
    if (f3 < 3'd4 && sz < 4 && v >= ((mask + 64'd1) >> 1)) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [2:0] f3, input logic [31:0] a);
    int          sh;
    logic [63:0] mask;
    logic [63:0] res;
    sh   = 8 * int'(a % 4);
    mask = ((64'd1 << (8 * acc_size(f3))) - 64'd1) << sh;
    res  = ({32'b0, old} & ~mask) | (({32'b0, wd} << sh) & mask);
    return res[31:0];
  endfunction

  // Issue one request starting at a negedge; returns at the negedge after the response.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold);
    int          k;
    int          we0;
    int          exp_lat;
    bit          exp_fault;
    logic [31:0] exp_rd;
    logic [31:0] idx;
    logic [31:0] held;
    k = 0;
    while (!req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_accept", req_ready, 1);
    exp_fault = ref_fault(we, f3, a);
    idx       = a / 4;
    exp_rd    = (exp_fault || we) ? 32'h0 : ref_load(ref_mem[idx[9:0]], f3, a);
    exp_lat   = exp_fault ? 1 : (!we ? 2 : (f3 == 3'd2 ? 2 : 3));
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    we0 = we_edges;
    @(negedge clk);
    if (!hold) begin
      req_valid  = 1'b0;
      req_we     = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = $urandom;
      req_wdata  = $urandom;
    end
    k = 1;
    while (!resp_valid && k < 8) begin
      check("ready_low_while_busy", req_ready, 0);
      @(negedge clk);
      k++;
    end
    check("latency", k, exp_lat);
    check("resp_fault", resp_fault, exp_fault);
    check("resp_rdata", resp_rdata, exp_rd);
    check("ready_low_in_resp", req_ready, 0);
    held = resp_rdata;
    @(negedge clk);
    check("resp_single_pulse", resp_valid, 0);
    check("ready_after_resp", req_ready, 1);
    check("idle_mem_a", mem_A, 0);
    check("idle_mem_wd", mem_WD, 0);
    check("rdata_held", resp_rdata, held);
    check("write_count", we_edges - we0, (we && !exp_fault) ? 1 : 0);
    if (we && !exp_fault) ref_mem[idx[9:0]] = ref_store(ref_mem[idx[9:0]], wd, f3, a);
    if (!exp_fault) check("mem_word", mem[idx[9:0]], ref_mem[idx[9:0]]);
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    pre_idx = idx;
    pre_data = data;
    pre_we = 1'b1;
    ref_mem[idx] = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Accept a store, then assert reset in the cycle after the accept edge.
  task automatic abort_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int          we0;
    logic [31:0] idx;
    idx = a / 4;
    check("abort_ready", req_ready, 1);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    we0 = we_edges;
    check("abort_we_before_rst", mem_WE, (f3 == 3'd2) ? 1 : 0);
    #2 rst = 1'b1;
    #1;
    check("rst_mem_we", mem_WE, 0);
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_fault", resp_fault, 0);
    check("rst_mem_a", mem_A, 0);
    check("rst_mem_wd", mem_WD, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_resp_after_abort", resp_valid, 0);
    end
    check("abort_no_write", we_edges - we0, 0);
    check("abort_mem_kept", mem[idx[9:0]], ref_mem[idx[9:0]]);
  endtask

  initial begin
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a;
    int          idx;
    #1;
    check("reset_ready", req_ready, 0);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_resp_rdata", resp_rdata, 0);
    check("reset_resp_fault", resp_fault, 0);
    check("reset_mem_we", mem_WE, 0);
    check("reset_mem_a", mem_A, 0);
    check("reset_mem_wd", mem_WD, 0);
    @(negedge clk);
    for (int i = 0; i < int'(MemWords); i++) preload(10'(i), $urandom);
    rst = 1'b0;
    #1;
    check("ready_after_initial_rst", req_ready, 1);
    @(negedge clk);

    preload(10'd28, 32'h0000_0020);
    do_req(1'b0, 3'd2, 32'h70, 32'h0, 1'b0);
    check("lw_word28", resp_rdata, 32'h0000_0020);
    do_req(1'b1, 3'd2, 32'h40, 32'h1122_3344, 1'b0);
    do_req(1'b0, 3'd0, 32'h41, 32'h0, 1'b0);
    check("lb_0x41", resp_rdata, 32'h0000_0033);
    do_req(1'b0, 3'd5, 32'h42, 32'h0, 1'b0);
    check("lhu_0x42", resp_rdata, 32'h0000_1122);
    do_req(1'b1, 3'd0, 32'h41, 32'hFFFF_FFAB, 1'b0);
    check("sb_merge_word16", mem[16], 32'h1122_AB44);
    do_req(1'b0, 3'd0, 32'h41, 32'h0, 1'b0);
    check("lb_sext", resp_rdata, 32'hFFFF_FFAB);
    do_req(1'b0, 3'd4, 32'h41, 32'h0, 1'b0);
    check("lbu_zext", resp_rdata, 32'h0000_00AB);

    do_req(1'b0, 3'd1, 32'h73, 32'h0, 1'b0);
    do_req(1'b1, 3'd2, 32'h42, 32'hCAFE_F00D, 1'b0);
    do_req(1'b0, 3'd3, 32'h10, 32'h0, 1'b0);
    do_req(1'b0, 3'd2, 32'h1000, 32'h0, 1'b0);
    do_req(1'b1, 3'd6, 32'h20, 32'h5555_5555, 1'b0);

    abort_req(3'd2, 32'h40, 32'hDEAD_BEEF);
    abort_req(3'd0, 32'h45, 32'h0000_0077);

    do_req(1'b1, 3'd2, 32'h80, 32'hA5A5_5A5A, 1'b1);
    do_req(1'b0, 3'd2, 32'h80, 32'h0, 1'b1);
    do_req(1'b1, 3'd1, 32'h82, 32'h0000_BEEF, 1'b1);
    req_valid = 1'b0;
    check("sh_after_b2b", mem[32], 32'hBEEF_5A5A);

    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 4) + (($urandom_range(0, 4) > 2) ? 2 : 0)) % 3'd6;
      idx = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1024, 1100))
                                          : int'($urandom_range(0, 1023));
      a = 32'(idx) * 4;
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(0, 3));
      else if (f3 == 3'd0 || f3 == 3'd4) a = a + 32'($urandom_range(0, 3));
      else if (f3 == 3'd1 || f3 == 3'd5) a = a + 32'($urandom_range(0, 1) * 2);
      do_req(we, f3, a, $urandom, ($urandom_range(0, 3) == 0));
    end
    req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
